// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the core load/store
// unit (port 0) and the debug/loader port (port 1). Round-robin arbitration, a
// one-cycle read return steered to the winner, and a bounded loader lock so
// long bursts cannot starve the core.
module dmem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic                clk,
  input  logic                rst,
  // port 0: core load/store unit
  input  logic                p0_req,
  input  logic                p0_we,
  input  logic [ADDR_W-1:0]   p0_addr,
  input  logic [DATA_W-1:0]   p0_wdata,
  input  logic [DATA_W/8-1:0] p0_wmask,
  output logic                p0_gnt,
  output logic                p0_rvalid,
  output logic [DATA_W-1:0]   p0_rdata,
  // port 1: debug/loader
  input  logic                p1_req,
  input  logic                p1_we,
  input  logic [ADDR_W-1:0]   p1_addr,
  input  logic [DATA_W-1:0]   p1_wdata,
  input  logic [DATA_W/8-1:0] p1_wmask,
  input  logic                p1_lock,
  output logic                p1_gnt,
  output logic                p1_rvalid,
  output logic [DATA_W-1:0]   p1_rdata,
  output logic                p1_locked,
  // data memory side
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

  typedef enum logic {
    ST_ARB,
    ST_LOCKED
  } state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] lock_cnt;
  logic             last_winner;  // 0 = port 0 won last grant, 1 = port 1
  logic             rd_pend;
  logic             rd_port;

  logic             gnt0, gnt1;
  logic             arb_en;       // round-robin decides this cycle
  logic             lw_eff;       // last_winner as seen by the round-robin
  logic             timeout;

  assign timeout = (state == ST_LOCKED) && (lock_cnt == CNT_MAX);

  // Next-state and grant decision. When the lock is dropped or times out the
  // same cycle already arbitrates normally, so a waiting core gets in at once.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    next_state = state;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    arb_en     = 1'b0;
    lw_eff     = last_winner;
    case (state)
      ST_ARB: arb_en = 1'b1;
      ST_LOCKED: begin
        if (timeout) begin
          // Timeout: pretend port 1 won last so a pending core request wins.
          arb_en     = 1'b1;
          lw_eff     = 1'b1;
          next_state = ST_ARB;
        end else if (!p1_lock) begin
          arb_en     = 1'b1;
          next_state = ST_ARB;
        end else begin
          gnt1 = p1_req;
        end
      end
      default: next_state = ST_ARB;
    endcase
    if (arb_en) begin
      if (p0_req && p1_req) begin
        gnt0 = lw_eff;
        gnt1 = !lw_eff;
      end else begin
        gnt0 = p0_req;
        gnt1 = p1_req;
      end
      // Only a fresh grant out of ARB may take the lock.
      if (state == ST_ARB && gnt1 && p1_lock) next_state = ST_LOCKED;
    end
    // Reset forces every output low, including the combinational grants.
    if (rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  // State register, lock counter, round-robin pointer and read-return tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_ARB;
      lock_cnt    <= '0;
      last_winner <= 1'b1;
      rd_pend     <= 1'b0;
      rd_port     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state <= next_state;
      if (next_state == ST_LOCKED) begin
        if (state == ST_ARB)          lock_cnt <= CNT_W'(1);
        else if (lock_cnt != CNT_MAX) lock_cnt <= lock_cnt + CNT_W'(1);
      end else begin
        lock_cnt <= '0;
      end
      if (gnt0)         last_winner <= 1'b0;
      else if (gnt1)    last_winner <= 1'b1;
      else if (timeout) last_winner <= 1'b1;
      rd_pend <= (gnt0 && !p0_we) || (gnt1 && !p1_we);
      rd_port <= gnt1;
    end
  end

  // Memory-side mux: granted port's fields, all zero when idle.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    if (gnt0) begin
      mem_we    = p0_we;
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
      mem_wmask = p0_wmask;
    end else if (gnt1) begin
      mem_we    = p1_we;
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
      mem_wmask = p1_wmask;
    end
  end

  assign mem_en    = gnt0 || gnt1;
  assign p0_gnt    = gnt0;
  assign p1_gnt    = gnt1;
  assign p1_locked = (state == ST_LOCKED);

  // Read return is steered to the port that owned the read one cycle earlier.
  assign p0_rvalid = rd_pend && !rd_port;
  assign p1_rvalid = rd_pend && rd_port;
  assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
  assign p1_rdata  = p1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter. A behavioural memory
// answers the DUT; a reference copy of memory contents supplies expected read
// data, queued at grant time and compared when the read returns.
module tb_dmem_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              p0_req, p0_we, p0_gnt, p0_rvalid;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata, p0_rdata;
  logic [3:0]        p0_wmask;
  logic              p1_req, p1_we, p1_gnt, p1_rvalid, p1_lock, p1_locked;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata, p1_rdata;
  logic [3:0]        p1_wmask;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wmask;
  logic [DATA_W-1:0] mem_rdata;

  typedef struct {
    logic              port;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

  sb_entry_t         sb[$];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] tb_mem  [DEPTH];
  logic              mem_ready = 1'b0;
  int                tests_run = 0;
  int                tests_failed = 0;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(16)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_wmask(p0_wmask), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_wmask(p1_wmask), .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata), .p1_locked(p1_locked),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] init_word(input int a);
    return 32'hA500_0000 ^ DATA_W'(a * 3);
  endfunction

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                              input logic [DATA_W-1:0] new_w,
                                              input logic [3:0] mask);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (mask[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  // Behavioural single-port memory with one-cycle read latency.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < DEPTH; i++) tb_mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) tb_mem[mem_addr] <= merge(tb_mem[mem_addr], mem_wdata, mem_wmask);
      else        mem_rdata <= tb_mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_p0_gnt"},    32'(p0_gnt),    0);
    check({tag, "_p1_gnt"},    32'(p1_gnt),    0);
    check({tag, "_p0_rvalid"}, 32'(p0_rvalid), 0);
    check({tag, "_p1_rvalid"}, 32'(p1_rvalid), 0);
    check({tag, "_p0_rdata"},  p0_rdata,       0);
    check({tag, "_p1_rdata"},  p1_rdata,       0);
    check({tag, "_p1_locked"}, 32'(p1_locked), 0);
    check({tag, "_mem_en"},    32'(mem_en),    0);
    check({tag, "_mem_we"},    32'(mem_we),    0);
    check({tag, "_mem_addr"},  32'(mem_addr),  0);
    check({tag, "_mem_wdata"}, mem_wdata,      0);
    check({tag, "_mem_wmask"}, 32'(mem_wmask), 0);
  endtask

  task automatic idle_inputs();
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0; p0_wmask = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0; p1_wmask = '0;
    p1_lock = 0;
  endtask

  // One clock cycle: check read return for the previous grant, check this
  // cycle's grant/lock/memory fields, and record expected effects.
  task automatic step(input logic eg0, input logic eg1, input logic el, input string tag);
    sb_entry_t e;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_p0_rvalid"}, 32'(p0_rvalid), 32'(e.port == 1'b0));
      check({tag, "_p1_rvalid"}, 32'(p1_rvalid), 32'(e.port == 1'b1));
      check({tag, "_rdata"}, e.port ? p1_rdata : p0_rdata, e.data);
      check({tag, "_other_rdata"}, e.port ? p0_rdata : p1_rdata, 0);
    end else begin
      check({tag, "_p0_rvalid"}, 32'(p0_rvalid), 0);
      check({tag, "_p1_rvalid"}, 32'(p1_rvalid), 0);
    end
    check({tag, "_p0_gnt"},    32'(p0_gnt),    32'(eg0));
    check({tag, "_p1_gnt"},    32'(p1_gnt),    32'(eg1));
    check({tag, "_p1_locked"}, 32'(p1_locked), 32'(el));
    check({tag, "_mem_en"},    32'(mem_en),    32'(eg0 | eg1));
    if (eg0 || eg1) begin
      check({tag, "_mem_addr"}, 32'(mem_addr), 32'(eg0 ? p0_addr : p1_addr));
      check({tag, "_mem_we"},   32'(mem_we),   32'(eg0 ? p0_we : p1_we));
      if (eg0 ? p0_we : p1_we) begin
        check({tag, "_mem_wdata"}, mem_wdata, eg0 ? p0_wdata : p1_wdata);
        check({tag, "_mem_wmask"}, 32'(mem_wmask), 32'(eg0 ? p0_wmask : p1_wmask));
        if (eg0) ref_mem[p0_addr] = merge(ref_mem[p0_addr], p0_wdata, p0_wmask);
        else     ref_mem[p1_addr] = merge(ref_mem[p1_addr], p1_wdata, p1_wmask);
      end else begin
        e.port = eg1;
        e.data = eg0 ? ref_mem[p0_addr] : ref_mem[p1_addr];
        sb.push_back(e);
      end
    end else begin
      check({tag, "_mem_addr_idle"}, 32'(mem_addr), 0);
    end
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle asynchronous reset: outputs must clear with no clock edge.
  task automatic reset_dut(input string tag);
    rst = 1'b1;
    #1;
    check_outputs_zero(tag);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("por");
    rst = 1'b0;

    // T1: single port 0 write then read back.
    p0_req = 1; p0_we = 1; p0_addr = 5; p0_wdata = 32'hDEAD_BEEF; p0_wmask = 4'hF;
    step(1, 0, 0, "t1_wr");
    p0_we = 0;
    step(1, 0, 0, "t1_rd");
    idle_inputs();
    step(0, 0, 0, "t1_ret");

    // T2: continuous reads on both ports from reset alternate, port 0 first.
    reset_dut("t2_rst");
    p0_req = 1; p0_addr = 10;
    p1_req = 1; p1_addr = 20;
    for (int i = 0; i < 8; i++) begin
      step(i % 2 == 0, i % 2 == 1, 0, $sformatf("t2_c%0d", i));
      if (i % 2 == 0) p0_addr = p0_addr + 1;
      else            p1_addr = p1_addr + 1;
    end
    idle_inputs();
    step(0, 0, 0, "t2_drain");

    // T3: port 1 locks for 4 writes; port 0 waits, wins when lock drops.
    p0_req = 1; p0_we = 1; p0_addr = 100; p0_wdata = 32'h1111_1111; p0_wmask = 4'hF;
    step(1, 0, 0, "t3_pre");
    p0_addr = 101; p0_wdata = 32'h2222_2222;
    p1_req = 1; p1_we = 1; p1_lock = 1; p1_addr = 200; p1_wdata = 32'hC0DE_0000;
    p1_wmask = 4'hF;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, i > 0, $sformatf("t3_lk%0d", i));
      p1_addr = p1_addr + 1; p1_wdata = p1_wdata + 1;
    end
    p1_req = 0; p1_lock = 0;
    step(1, 0, 1, "t3_drop");
    p0_req = 0;
    step(0, 0, 0, "t3_idle");

    // T4: lock held forever times out after exactly 16 grants.
    p0_req = 1; p0_we = 1; p0_addr = 102; p0_wdata = 32'h3333_3333; p0_wmask = 4'hF;
    p1_req = 1; p1_we = 1; p1_lock = 1; p1_addr = 300; p1_wdata = 32'h4444_0000;
    p1_wmask = 4'hF;
    for (int i = 0; i < 16; i++) begin
      step(0, 1, i > 0, $sformatf("t4_lk%0d", i));
      p1_wdata = p1_wdata + 1;
    end
    step(1, 0, 1, "t4_timeout");
    p0_req = 0;
    step(0, 1, 0, "t4_relock");
    step(0, 1, 1, "t4_relocked");
    p1_req = 0; p1_lock = 0;
    step(0, 0, 1, "t4_release");
    step(0, 0, 0, "t4_idle");

    // T5: read then write of same address back to back; read returns old data.
    p0_req = 1; p0_we = 0; p0_addr = 5;
    p1_req = 1; p1_we = 1; p1_addr = 5; p1_wdata = 32'h1234_5678; p1_wmask = 4'hF;
    step(1, 0, 0, "t5_rd");
    p0_req = 0;
    step(0, 1, 0, "t5_wr");
    p1_wdata = 32'hAAAA_5555; p1_wmask = 4'b0101;
    step(0, 1, 0, "t5_wr_mask");
    p1_req = 0;
    p0_req = 1;
    step(1, 0, 0, "t5_rd2");
    p0_addr = 202;
    step(1, 0, 0, "t5_rd3");
    idle_inputs();
    step(0, 0, 0, "t5_drain");

    // T6: reset during a pending read and during a lock.
    p0_req = 1; p0_we = 0; p0_addr = 5;
    step(1, 0, 0, "t6_rd");
    reset_dut("t6_rst_rd");
    idle_inputs();
    step(0, 0, 0, "t6_no_stale");
    p1_req = 1; p1_we = 1; p1_lock = 1; p1_addr = 400; p1_wdata = 32'h5A5A_5A5A;
    p1_wmask = 4'hF;
    step(0, 1, 0, "t6_lock");
    p0_req = 1; p0_we = 0; p0_addr = 20;
    step(0, 1, 1, "t6_locked");
    reset_dut("t6_rst_lk");
    p1_lock = 0; p1_we = 0; p1_addr = 21;
    step(1, 0, 0, "t6_tie");
    p0_req = 0;
    step(0, 1, 0, "t6_p1");
    idle_inputs();
    step(0, 0, 0, "t6_drain");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
